// File: rtl/ascon_pkg.sv
// Shared Ascon constants, round schedule and helpers.
// Used by the initialization stage and the downstream AEAD stages.
package ascon_pkg;

  localparam logic [63:0] ASCON128_IV = 64'h80400c0600000000;
  localparam int ROUNDS_A = 12;

  localparam int ROT0A = 19;
  localparam int ROT0B = 28;
  localparam int ROT1A = 61;
  localparam int ROT1B = 39;
  localparam int ROT2A = 1;
  localparam int ROT2B = 6;
  localparam int ROT3A = 10;
  localparam int ROT3B = 17;
  localparam int ROT4A = 7;
  localparam int ROT4B = 41;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ini_state_e;

  // Sequence F0, E1, D2, ... 4B for rnd = 0..11
  function automatic logic [7:0] round_const(
    input logic [3:0] rnd
  );
    return 8'hF0 - ({4'd0, rnd} * 8'h0F);
  endfunction

  function automatic logic [63:0] rotr(
    input logic [63:0] x,
    input int          n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round:
// constant addition, bit-sliced S-box, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] state_i,
  input  logic [7:0]   c_i,
  output logic [319:0] state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[319:256];
    x1 = state_i[255:192];
    x2 = state_i[191:128] ^ {56'b0, c_i};
    x3 = state_i[127:64];
    x4 = state_i[63:0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    x0 = x0 ^ rotr(x0, ROT0A) ^ rotr(x0, ROT0B);
    x1 = x1 ^ rotr(x1, ROT1A) ^ rotr(x1, ROT1B);
    x2 = x2 ^ rotr(x2, ROT2A) ^ rotr(x2, ROT2B);
    x3 = x3 ^ rotr(x3, ROT3A) ^ rotr(x3, ROT3B);
    x4 = x4 ^ rotr(x4, ROT4A) ^ rotr(x4, ROT4B);

    state_o = {x0, x1, x2, x3, x4};
  end

endmodule

// File: rtl/initialization.sv
// Ascon-128 initialization: loads IV||K||N, runs p^a one round
// per cycle, folds the key into x3/x4 and registers the result.
module initialization
  import ascon_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  output logic         busy,
  output logic         done,
  output logic [319:0] ini_sout
);

  ini_state_e   st_q;
  logic [3:0]   rnd_q;
  logic [127:0] key_q;
  logic [319:0] state_q;
  logic [319:0] state_d;

  ascon_round u_round (
    .state_i (state_q),
    .c_i     (round_const(rnd_q)),
    .state_o (state_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ST_IDLE;
      rnd_q    <= 4'd0;
      key_q    <= '0;
      state_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ini_sout <= '0;
    end else begin
      done <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= {ASCON128_IV, key, nonce};
            key_q   <= key;
            rnd_q   <= 4'd0;
            busy    <= 1'b1;
            st_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q <= state_d;
          if (rnd_q == 4'(ROUNDS - 1)) begin
            ini_sout <= state_d ^ {192'b0, key_q};
            done     <= 1'b1;
            busy     <= 1'b0;
            rnd_q    <= 4'd0;
            st_q     <= ST_IDLE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_initialization.sv
// Randomized self-checking bench for the Ascon-128 init stage
// against a table-driven behavioural permutation model.
module tb_initialization;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] nonce;
  logic         busy;
  logic         done;
  logic [319:0] ini_sout;

  int n_checks = 0;
  int n_err = 0;

  localparam logic [127:0] KAT_K = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  initialization dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .nonce    (nonce),
    .busy     (busy),
    .done     (done),
    .ini_sout (ini_sout)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [319:0] got,
    input logic [319:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] perm12(input logic [319:0] s);
    logic [63:0] x [5];
    logic [4:0] v;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
    for (int r = 0; r < 12; r++) begin
      x[2] ^= 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        for (int j = 0; j < 5; j++) x[j][b] = v[4 - j];
      end
      x[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
      x[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
      x[2] = x[2] ^ rr(x[2], 1) ^ rr(x[2], 6);
      x[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
      x[4] = x[4] ^ rr(x[4], 7) ^ rr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] init_model(
    input logic [127:0] k,
    input logic [127:0] n
  );
    logic [319:0] s;
    s = perm12({64'h80400c0600000000, k, n});
    s[127:0] = s[127:0] ^ k;
    return s;
  endfunction

  // Empty AD and empty PT: domain bit, padding block, finalization.
  function automatic logic [127:0] tag_model(
    input logic [319:0] s_in,
    input logic [127:0] k
  );
    logic [319:0] s;
    s = s_in;
    s[0] = s[0] ^ 1'b1;
    s[319] = s[319] ^ 1'b1;
    s[255:128] = s[255:128] ^ k;
    s = perm12(s);
    return s[127:0] ^ k;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_job(
    input logic [127:0] k,
    input logic [127:0] n,
    input bit           dup
  );
    int cyc;
    int dones;
    logic [319:0] exp;
    exp = init_model(k, n);
    @(negedge clk);
    start = 1'b1;
    key = k;
    nonce = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = r128();
    nonce = r128();
    check("busy_go", busy, 1);
    cyc = 0;
    dones = 0;
    while (cyc < 40) begin
      if (dup && cyc == 5) begin
        start = 1'b1;
        key = r128();
        nonce = r128();
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 6) check("busy_mid", busy, 1);
      if (done) begin
        dones++;
        if (dones == 1) begin
          check("latency", cyc, 12);
          check("sout", ini_sout, exp);
          check("busy_end", busy, 0);
        end
      end
    end
    check("n_done", dones, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] kq [64];
    logic [127:0] nq [64];
    bit ed;
    int dn;

    rst = 1'b0;
    start = 1'b0;
    key = '0;
    nonce = '0;
    #23;
    check("rst_sout", ini_sout, 0);
    check("rst_flags", {busy, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      check("idle_sout", ini_sout, 0);
      check("idle_flags", {busy, done}, 0);
    end

    run_job(KAT_K, KAT_K, 1'b0);
    check("kat_tag", tag_model(ini_sout, KAT_K), KAT_TAG);

    run_job(KAT_K, KAT_K, 1'b1);
    check("dup_tag", tag_model(ini_sout, KAT_K), KAT_TAG);

    for (int i = 0; i < 4; i++) run_job(r128(), r128(), 1'b0);

    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      start = (c < 30);
      key = r128();
      nonce = r128();
      kq[c] = key;
      nq[c] = nonce;
      @(posedge clk);
      #1;
      ed = (c == 12 || c == 25 || c == 38);
      check("b2b_done", done, ed);
      if (done && c >= 12)
        check("b2b_sout", ini_sout, init_model(kq[c - 12], nq[c - 12]));
      if (c == 20)
        check("b2b_hold", ini_sout, init_model(kq[0], nq[0]));
    end
    start = 1'b0;

    @(negedge clk);
    start = 1'b1;
    key = r128();
    nonce = r128();
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check("mrst_sout", ini_sout, 0);
    check("mrst_flags", {busy, done}, 0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("mrst_nodone", dn, 0);
    check("mrst_idle", ini_sout, 0);

    run_job(KAT_K, KAT_K, 1'b0);
    check("post_tag", tag_model(ini_sout, KAT_K), KAT_TAG);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
